// File: rtl/trace_pkg.sv
// Shared types and vector-layout helpers for the CPU register-trace checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// A vector word is packed as {opcode, mask, expected}: the expected register
// file occupies the low NUM_REGS*REG_W bits, then one mask bit per register,
// then the opcode at the top.
package trace_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRIME,
      RUN,
      DRAIN,
      DONE
   } state_t;

   function automatic int mask_lsb(input int num_regs, input int reg_w);
      return num_regs * reg_w;
   endfunction

   function automatic int op_lsb(input int num_regs, input int reg_w);
      return num_regs * reg_w + num_regs;
   endfunction

   function automatic int vec_width(input int op_w, input int num_regs, input int reg_w);
      return op_w + num_regs + num_regs * reg_w;
   endfunction

endpackage

// File: rtl/trace_cmp.sv
// Masked per-register compare of a register-file snapshot against expected values.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports: snapshot/expected are packed register files (register NUM_REGS-1 in
// the MSBs); mask selects which registers are checked; mismatch has one bit
// per register, set when that register is checked and differs.
module trace_cmp
   import trace_pkg::*;
#(
   parameter int NUM_REGS = 8,
   parameter int REG_W    = 8
) (
   input  logic [NUM_REGS*REG_W-1:0] snapshot,
   input  logic [NUM_REGS*REG_W-1:0] expected,
   input  logic [NUM_REGS-1:0]       mask,
   output logic [NUM_REGS-1:0]       mismatch
);

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      assign mismatch[i] = mask[i] & (snapshot[i*REG_W +: REG_W] != expected[i*REG_W +: REG_W]);
   end

endmodule

// File: rtl/cpu_trace_checker.sv
// Pairs each retired instruction with its expected vector from a sync-read ROM and counts errors.
// Latency: ROM data 1 cycle after vec_rd; err_valid 1 cycle after the failing check_strobe.
// Backpressure: none; a fetch that outruns the prefetch sets sticky overrun and uses stale data.
//
// Ports: clk/rst (sync, active high); start + num_vectors launch a run;
// fetch_strobe/hold/fetch_op tap the opcode fetch; check_strobe/snapshot tap
// the register file at T4; vec_addr/vec_rd/vec_data drive the vector ROM;
// busy/done/pass, counters, err_* pulse and first_err_* capture report status.
module cpu_trace_checker
   import trace_pkg::*;
#(
   parameter int  NUM_REGS = 8,
   parameter int  REG_W    = 8,
   parameter int  OP_W     = 8,
   parameter int  ADDR_W   = 16,
   parameter int  ERR_W    = 16,
   localparam int VEC_W    = vec_width(OP_W, NUM_REGS, REG_W)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [ADDR_W:0]           num_vectors,
   input  logic                      fetch_strobe,
   input  logic                      hold,
   input  logic [OP_W-1:0]           fetch_op,
   input  logic                      check_strobe,
   input  logic [NUM_REGS*REG_W-1:0] snapshot,
   output logic [ADDR_W-1:0]         vec_addr,
   output logic                      vec_rd,
   input  logic [VEC_W-1:0]          vec_data,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic [ADDR_W:0]           vec_count,
   output logic [ERR_W-1:0]          error_count,
   output logic [ERR_W-1:0]          op_err_count,
   output logic                      err_valid,
   output logic [ADDR_W:0]           err_index,
   output logic [NUM_REGS-1:0]       err_reg_mask,
   output logic [ADDR_W:0]           first_err_index,
   output logic                      first_err_valid,
   output logic                      overrun
);

   localparam int SNAP_W   = NUM_REGS * REG_W;
   localparam int MASK_LSB = mask_lsb(NUM_REGS, REG_W);
   localparam int OP_LSB   = op_lsb(NUM_REGS, REG_W);
   localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

   state_t state, state_nxt;

   logic [ADDR_W:0]     n_vec;
   logic [ADDR_W:0]     fetch_idx;
   logic [ADDR_W:0]     fetch_idx_nxt;
   logic [ADDR_W:0]     chk_idx;
   logic [VEC_W-1:0]    next_vec;      // prefetched vector for the next fetch
   logic                next_vld;
   logic [OP_LSB-1:0]   chk_vec;       // {mask, expected} of the instruction awaiting check
   logic                chk_vld;
   logic                rd_pending;    // ROM read issued last cycle, data on vec_data now
   logic                start_go;
   logic                fetch_go;
   logic                check_go;
   logic                rd_fetch;
   logic [NUM_REGS-1:0] mismatch;

   assign start_go      = start & ((state == IDLE) | (state == DONE));
   assign fetch_go      = (state == RUN) & fetch_strobe & ~hold;
   assign check_go      = check_strobe & chk_vld;
   assign fetch_idx_nxt = fetch_idx + IDX_ONE;
   // The final fetch needs no prefetch behind it.
   assign rd_fetch      = fetch_go & (fetch_idx_nxt < n_vec);

   assign pass = (state == DONE) & (error_count == '0) & (op_err_count == '0) & ~overrun;

   trace_cmp #(
      .NUM_REGS (NUM_REGS),
      .REG_W    (REG_W)
   ) u_cmp (
      .snapshot (snapshot),
      .expected (chk_vec[SNAP_W-1:0]),
      .mask     (chk_vec[MASK_LSB +: NUM_REGS]),
      .mismatch (mismatch)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      vec_rd    = 1'b0;
      vec_addr  = '0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = (num_vectors == '0) ? DONE : PRIME;
         end
         PRIME: begin
            busy      = 1'b1;
            vec_rd    = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (rd_fetch) begin
               vec_rd   = 1'b1;
               vec_addr = fetch_idx_nxt[ADDR_W-1:0];
            end
            if (fetch_go && (fetch_idx_nxt == n_vec)) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (!chk_vld || check_go) state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_nxt = (num_vectors == '0) ? DONE : PRIME;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         n_vec           <= '0;
         fetch_idx       <= '0;
         chk_idx         <= '0;
         next_vec        <= '0;
         next_vld        <= 1'b0;
         chk_vec         <= '0;
         chk_vld         <= 1'b0;
         rd_pending      <= 1'b0;
         vec_count       <= '0;
         error_count     <= '0;
         op_err_count    <= '0;
         err_valid       <= 1'b0;
         err_index       <= '0;
         err_reg_mask    <= '0;
         first_err_index <= '0;
         first_err_valid <= 1'b0;
         overrun         <= 1'b0;
      end else begin
         err_valid  <= 1'b0;
         rd_pending <= vec_rd;
         if (start_go) begin
            n_vec           <= num_vectors;
            fetch_idx       <= '0;
            next_vld        <= 1'b0;
            chk_vld         <= 1'b0;
            vec_count       <= '0;
            error_count     <= '0;
            op_err_count    <= '0;
            err_index       <= '0;
            err_reg_mask    <= '0;
            first_err_index <= '0;
            first_err_valid <= 1'b0;
            overrun         <= 1'b0;
         end else begin
            // A fetch landing on top of returning data has already consumed the
            // stale vector; that data belongs to it, so it is dropped.
            if (fetch_go) begin
               next_vld <= 1'b0;
            end else if (rd_pending) begin
               next_vec <= vec_data;
               next_vld <= 1'b1;
            end

            // Check runs on the pre-shift chk_vec; a same-cycle fetch refills it below.
            if (check_go) begin
               chk_vld <= 1'b0;
               if (~&vec_count) vec_count <= vec_count + IDX_ONE;
               if (|mismatch) begin
                  if (~&error_count) error_count <= error_count + ERR_ONE;
                  err_valid    <= 1'b1;
                  err_index    <= chk_idx;
                  err_reg_mask <= mismatch;
                  if (!first_err_valid) begin
                     first_err_valid <= 1'b1;
                     first_err_index <= chk_idx;
                  end
               end
            end

            if (fetch_go) begin
               chk_vec   <= next_vec[OP_LSB-1:0];
               chk_vld   <= 1'b1;
               chk_idx   <= fetch_idx;
               fetch_idx <= fetch_idx_nxt;
               if (!next_vld) overrun <= 1'b1;
               if ((fetch_op != next_vec[OP_LSB +: OP_W]) && (~&op_err_count))
                  op_err_count <= op_err_count + ERR_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Bench for cpu_trace_checker: table-driven runs, hold/overrun and reset sequences, random runs.
// Latency: n/a.
// Backpressure: n/a.
module tb_cpu_trace_checker;

   localparam int NR = 8;
   localparam int RW = 8;
   localparam int OW = 8;
   localparam int AW = 16;
   localparam int EW = 2;               // narrow counters so saturation is reached
   localparam int VW = OW + NR + NR * RW;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [AW:0]       num_vectors = '0;
   logic              fetch_strobe = 1'b0;
   logic              hold = 1'b0;
   logic [OW-1:0]     fetch_op = '0;
   logic              check_strobe = 1'b0;
   logic [NR*RW-1:0]  snapshot = '0;
   logic [AW-1:0]     vec_addr;
   logic              vec_rd;
   logic [VW-1:0]     vec_data = '0;
   logic              busy, done, pass;
   logic [AW:0]       vec_count;
   logic [EW-1:0]     error_count, op_err_count;
   logic              err_valid;
   logic [AW:0]       err_index;
   logic [NR-1:0]     err_reg_mask;
   logic [AW:0]       first_err_index;
   logic              first_err_valid;
   logic              overrun;

   always #5 clk = ~clk;

   cpu_trace_checker #(
      .NUM_REGS (NR), .REG_W (RW), .OP_W (OW), .ADDR_W (AW), .ERR_W (EW)
   ) dut (
      .clk (clk), .rst (rst), .start (start), .num_vectors (num_vectors),
      .fetch_strobe (fetch_strobe), .hold (hold), .fetch_op (fetch_op),
      .check_strobe (check_strobe), .snapshot (snapshot),
      .vec_addr (vec_addr), .vec_rd (vec_rd), .vec_data (vec_data),
      .busy (busy), .done (done), .pass (pass), .vec_count (vec_count),
      .error_count (error_count), .op_err_count (op_err_count),
      .err_valid (err_valid), .err_index (err_index), .err_reg_mask (err_reg_mask),
      .first_err_index (first_err_index), .first_err_valid (first_err_valid),
      .overrun (overrun)
   );

   // Vector ROM (sync read) and per-vector stimulus for the current run.
   logic [VW-1:0]    rom    [64];
   logic [NR*RW-1:0] snap_a [64];
   logic [OW-1:0]    fop_a  [64];

   always @(posedge clk) if (vec_rd) vec_data <= rom[vec_addr[5:0]];

   typedef struct packed {
      logic [AW:0]   idx;
      logic [NR-1:0] m;
   } errrec_t;
   errrec_t got_q[$];
   errrec_t exp_q[$];

   always @(negedge clk) if (err_valid) got_q.push_back({err_index, err_reg_mask});

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NR*RW-1:0] base_regs(input int k);
      logic [NR*RW-1:0] r;
      for (int i = 0; i < NR; i++)
         r[i*RW +: RW] = (i == 6) ? 8'h12 : 8'(i * 16 + k);   // B is 8'h12 everywhere
      return r;
   endfunction

   task automatic load_base(input int n);
      for (int k = 0; k < n; k++) begin
         rom[k]    = {8'h06, 8'hFF, base_regs(k)};
         snap_a[k] = base_regs(k);
         fop_a[k]  = 8'h06;
      end
   endtask

   // Expected results straight from the checking rules: per-vector masked
   // register difference, opcode inequality, saturating tallies.
   task automatic model(input int n, output int ec, output int oe, output int fv, output int fi);
      logic [NR*RW-1:0] e;
      logic [NR-1:0]    m, d;
      logic [OW-1:0]    op;
      logic [AW:0]      kk;
      ec = 0; oe = 0; fv = 0; fi = 0;
      exp_q.delete();
      for (int k = 0; k < n; k++) begin
         e  = rom[k][NR*RW-1:0];
         m  = rom[k][NR*RW +: NR];
         op = rom[k][VW-1 -: OW];
         d  = '0;
         for (int i = 0; i < NR; i++)
            if (m[i] && (e[i*RW +: RW] != snap_a[k][i*RW +: RW])) d[i] = 1'b1;
         if (d != '0) begin
            ec++;
            kk = k[AW:0];
            exp_q.push_back({kk, d});
            if (fv == 0) begin fv = 1; fi = k; end
         end
         if (op != fop_a[k]) oe++;
      end
      if (ec > 3) ec = 3;
      if (oe > 3) oe = 3;
   endtask

   task automatic wait_done();
      int w = 0;
      while (!done && w < 100) begin cyc(); w++; end
      chk("done_reached", done, 1);
   endtask

   // overlap: check of k-1 shares the cycle with fetch of k.
   // noise:   held fetch_strobe pulses in idle cycles, which must be ignored.
   task automatic drive_run(input int n, input bit overlap, input bit noise);
      got_q.delete();
      num_vectors = n[AW:0];
      start = 1'b1;
      cyc();
      start = 1'b0;
      if (n > 0) begin
         cyc(); cyc(); cyc();
         for (int k = 0; k < n; k++) begin
            fetch_strobe = 1'b1;
            fetch_op     = fop_a[k];
            if (overlap && k > 0) begin check_strobe = 1'b1; snapshot = snap_a[k-1]; end
            cyc();
            fetch_strobe = 1'b0; check_strobe = 1'b0;
            cyc();
            if (noise && $urandom_range(0, 1) == 1) begin
               hold = 1'b1; fetch_strobe = 1'b1; fetch_op = 8'($urandom);
            end
            cyc();
            hold = 1'b0; fetch_strobe = 1'b0;
            if (!overlap) begin
               snapshot = snap_a[k]; check_strobe = 1'b1;
               cyc();
               check_strobe = 1'b0;
               cyc();
            end
         end
         if (overlap) begin
            snapshot = snap_a[n-1]; check_strobe = 1'b1;
            cyc();
            check_strobe = 1'b0;
         end
      end
      wait_done();
      cyc(); cyc();
   endtask

   task automatic cmp_pulses();
      chk("err_pulse_count", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         chk("err_pulse_index", got_q[i].idx, exp_q[i].idx);
         chk("err_pulse_mask", got_q[i].m, exp_q[i].m);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_pass"}, pass, 0);
      chk({tag, "_vec_count"}, vec_count, 0);
      chk({tag, "_error_count"}, error_count, 0);
      chk({tag, "_op_err_count"}, op_err_count, 0);
      chk({tag, "_err_valid"}, err_valid, 0);
      chk({tag, "_err_index"}, err_index, 0);
      chk({tag, "_err_reg_mask"}, err_reg_mask, 0);
      chk({tag, "_first_err_index"}, first_err_index, 0);
      chk({tag, "_first_err_valid"}, first_err_valid, 0);
      chk({tag, "_overrun"}, overrun, 0);
      chk({tag, "_vec_rd"}, vec_rd, 0);
      chk({tag, "_vec_addr"}, vec_addr, 0);
   endtask

   typedef struct {
      int         n;
      int         bad_vec;      // vector whose B snapshot/mask is altered, -1 none
      logic [7:0] snap_xor;     // xor applied to snapshot register B
      logic [7:0] mask_clr;     // mask bits cleared in that vector
      int         op_bad_vec;   // vector whose fetched opcode is replaced, -1 none
      logic [7:0] bad_op;
      bit         e_pass;
      int         e_vc;
      int         e_ec;
      int         e_oe;
      bit         e_fv;
      int         e_fi;
      logic [7:0] e_emask;
   } tcase_t;

   initial begin
      tcase_t tbl[5];
      int ec, oe, fv, fi;

      tbl[0] = '{3, -1, 8'h00, 8'h00, -1, 8'h00, 1'b1, 3, 0, 0, 1'b0, 0, 8'h00};
      tbl[1] = '{3,  1, 8'h01, 8'h00, -1, 8'h00, 1'b0, 3, 1, 0, 1'b1, 1, 8'h40};
      tbl[2] = '{3,  1, 8'h01, 8'h40, -1, 8'h00, 1'b1, 3, 0, 0, 1'b0, 0, 8'h00};
      tbl[3] = '{3, -1, 8'h00, 8'h00,  0, 8'h3E, 1'b0, 3, 0, 1, 1'b0, 0, 8'h00};
      tbl[4] = '{0, -1, 8'h00, 8'h00, -1, 8'h00, 1'b1, 0, 0, 0, 1'b0, 0, 8'h00};

      // Reset state.
      rst = 1'b1;
      cyc(); cyc();
      check_zero("reset");
      rst = 1'b0;
      cyc();

      // Table-driven runs.
      for (int t = 0; t < 5; t++) begin
         load_base(3);
         if (tbl[t].bad_vec >= 0) begin
            snap_a[tbl[t].bad_vec][6*RW +: RW] = snap_a[tbl[t].bad_vec][6*RW +: RW] ^ tbl[t].snap_xor;
            rom[tbl[t].bad_vec][NR*RW +: NR]  = rom[tbl[t].bad_vec][NR*RW +: NR] & ~tbl[t].mask_clr;
         end
         if (tbl[t].op_bad_vec >= 0) fop_a[tbl[t].op_bad_vec] = tbl[t].bad_op;
         drive_run(tbl[t].n, t[0], 1'b0);
         model(tbl[t].n, ec, oe, fv, fi);
         chk("tbl_pass", pass, tbl[t].e_pass);
         chk("tbl_vec_count", vec_count, tbl[t].e_vc);
         chk("tbl_error_count", error_count, tbl[t].e_ec);
         chk("tbl_op_err_count", op_err_count, tbl[t].e_oe);
         chk("tbl_first_err_valid", first_err_valid, tbl[t].e_fv);
         chk("tbl_first_err_index", first_err_index, tbl[t].e_fi);
         chk("tbl_err_reg_mask", err_reg_mask, tbl[t].e_emask);
         chk("tbl_busy", busy, 0);
         cmp_pulses();
      end

      // Held fetches consume nothing; back-to-back fetch outruns the prefetch.
      load_base(3);
      num_vectors = 3;
      start = 1'b1; cyc(); start = 1'b0;
      cyc(); cyc(); cyc();
      fetch_strobe = 1'b1; fetch_op = 8'h06; cyc(); fetch_strobe = 1'b0;
      cyc(); cyc();
      snapshot = snap_a[0]; check_strobe = 1'b1; cyc(); check_strobe = 1'b0;
      cyc();
      chk("hold_pre_vec_count", vec_count, 1);
      hold = 1'b1;
      fetch_strobe = 1'b1; cyc(); fetch_strobe = 1'b0; cyc();
      fetch_strobe = 1'b1; cyc(); fetch_strobe = 1'b0; hold = 1'b0;
      cyc();
      snapshot = snap_a[0]; check_strobe = 1'b1; cyc(); check_strobe = 1'b0;
      chk("hold_vec_count", vec_count, 1);
      chk("hold_overrun", overrun, 0);
      chk("hold_busy", busy, 1);
      fetch_strobe = 1'b1; fetch_op = 8'h06; cyc();
      cyc();                               // second fetch one cycle after the first
      fetch_strobe = 1'b0;
      chk("overrun_set", overrun, 1);
      snapshot = snap_a[1]; check_strobe = 1'b1; cyc(); check_strobe = 1'b0;
      wait_done();
      chk("overrun_pass", pass, 0);
      chk("overrun_vec_count", vec_count, 2);
      chk("overrun_error_count", error_count, 0);
      chk("overrun_op_err_count", op_err_count, 0);

      // Reset mid-run after two checks, then restart.
      load_base(4);
      snap_a[0][6*RW +: RW] = 8'h77;
      num_vectors = 4;
      start = 1'b1; cyc(); start = 1'b0;
      cyc(); cyc(); cyc();
      for (int k = 0; k < 2; k++) begin
         fetch_strobe = 1'b1; fetch_op = 8'h06; cyc(); fetch_strobe = 1'b0;
         cyc(); cyc();
         snapshot = snap_a[k]; check_strobe = 1'b1; cyc(); check_strobe = 1'b0;
         cyc();
      end
      chk("midrun_error_count", error_count, 1);
      chk("midrun_vec_count", vec_count, 2);
      fetch_strobe = 1'b1; cyc(); fetch_strobe = 1'b0;    // leaves a ROM read in flight
      rst = 1'b1;
      cyc();
      check_zero("midrun_rst");
      rst = 1'b0;
      cyc();
      load_base(3);
      drive_run(3, 1'b0, 1'b0);
      chk("restart_pass", pass, 1);
      chk("restart_vec_count", vec_count, 3);
      chk("restart_error_count", error_count, 0);
      chk("restart_overrun", overrun, 0);
      drive_run(0, 1'b0, 1'b0);
      chk("zero_run_pass", pass, 1);
      chk("zero_run_vec_count", vec_count, 0);

      // Random runs against the reference model.
      for (int r = 0; r < 25; r++) begin
         int n;
         logic [OW-1:0]    op;
         logic [NR*RW-1:0] e;
         n = $urandom_range(1, 12);
         for (int k = 0; k < n; k++) begin
            op = 8'($urandom);
            e  = {$urandom, $urandom};
            rom[k]    = {op, 8'($urandom), e};
            fop_a[k]  = ($urandom_range(0, 3) == 0) ? (op ^ 8'($urandom_range(1, 255))) : op;
            snap_a[k] = ($urandom_range(0, 2) == 0) ? (e ^ {$urandom, $urandom}) : e;
         end
         drive_run(n, 1'($urandom_range(0, 1)), 1'b1);
         model(n, ec, oe, fv, fi);
         chk("rnd_pass", pass, (ec == 0 && oe == 0) ? 1 : 0);
         chk("rnd_vec_count", vec_count, n);
         chk("rnd_error_count", error_count, ec);
         chk("rnd_op_err_count", op_err_count, oe);
         chk("rnd_first_err_valid", first_err_valid, fv);
         chk("rnd_first_err_index", first_err_index, fi);
         chk("rnd_overrun", overrun, 0);
         cmp_pulses();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
